// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small request FIFO: edge-triggered byte requests are
// queued and serialised back-to-back (start, LSB-first data, optional parity, stop).
module uart_tx_fifo #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              order,
   input  logic [DATA_W-1:0] data,
   output logic              sgn,
   output logic              out,
   output logic              full,
   output logic              err
);

   localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_W);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              order_q, order_d;
   logic              full_q, full_d;
   logic              err_q, err_d;
   logic              out_q, out_d;
   logic              sgn_q, sgn_d;
   logic              line_busy_q, line_busy_d;

   logic push, pop, baud_last;

   // FSM next state, FIFO bookkeeping and registered outputs
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_d       = par_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      order_d     = order;
      err_d       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      baud_last   = (baud_q == BAUD_W'(CLK_DIV - 1));

      if (order && !order_q) begin
         if (!full_q) push = 1'b1;
         else         err_d = 1'b1;
      end

      baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_PAR: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Parity is captured with the payload so the PAR state needs no shift history
      if (pop) begin
         shift_d  = mem_q[rd_ptr_q];
         par_d    = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         mem_d[wr_ptr_q] = data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      full_d  = (count_d == CNT_W'(FIFO_DEPTH));

      case (state_q)
         S_START: out_d = 1'b0;
         S_DATA:  out_d = shift_q[0];
         S_PAR:   out_d = par_q;
         default: out_d = 1'b1;
      endcase

      // line_busy tracks the output stage so busy covers the last stop bit on the pin
      line_busy_d = (state_q != S_IDLE);
      sgn_d       = (count_q != '0) || (state_q != S_IDLE) || line_busy_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         order_q     <= 1'b1;
         full_q      <= 1'b0;
         err_q       <= 1'b0;
         out_q       <= 1'b1;
         sgn_q       <= 1'b0;
         line_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         order_q     <= order_d;
         full_q      <= full_d;
         err_q       <= err_d;
         out_q       <= out_d;
         sgn_q       <= sgn_d;
         line_busy_q <= line_busy_d;
      end
   end

   assign sgn  = sgn_q;
   assign out  = out_q;
   assign full = full_q;
   assign err  = err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameter variants share stimulus; a line monitor
// decodes each frame and compares it against a per-instance queue of expected bytes.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst_n;
   logic       order;
   logic [7:0] data;
   logic       out0, out1, out2, sgn0, sgn1, sgn2;
   logic       full0, full1, full2, err0, err1, err2;
   wire  [2:0] out_v  = {out2, out1, out0};
   wire  [2:0] sgn_v  = {sgn2, sgn1, sgn0};
   wire  [2:0] full_v = {full2, full1, full0};
   wire  [2:0] err_v  = {err2, err1, err0};

   // instance 0: defaults, 1: even parity + 2 stop bits, 2: odd parity
   uart_tx_fifo u_def (.clk(clk), .rst(rst_n), .order(order), .data(data),
                       .sgn(sgn0), .out(out0), .full(full0), .err(err0));
   uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u_even (.clk(clk), .rst(rst_n), .order(order),
                       .data(data), .sgn(sgn1), .out(out1), .full(full1), .err(err1));
   uart_tx_fifo #(.PARITY(1)) u_odd (.clk(clk), .rst(rst_n), .order(order), .data(data),
                       .sgn(sgn2), .out(out2), .full(full2), .err(err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int DIV = 16;
   localparam int SGN_FALL [3] = '{161, 193, 177};
   localparam int NBITS    [3] = '{10, 12, 11};
   localparam int PARM     [3] = '{0, 2, 1};

   int checks, errors;
   logic [7:0] q0[$], q1[$], q2[$];

   int         m_busy [3];
   int         m_cyc  [3];
   int         m_bad  [3];
   int         m_idle [3];
   int         m_has  [3];
   int         frames [3];
   int         b2b    [3];
   logic [7:0] m_exp  [3];
   logic [7:0] m_got  [3];
   logic [11:0] samp  [3];

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_all(input logic [7:0] d);
      q0.push_back(d); q1.push_back(d); q2.push_back(d);
   endtask

   function automatic logic exp_line(input int i, input logic [7:0] d, input int b);
      logic [7:0] dd;
      dd = d;
      if (b == 0) return 1'b0;
      if (b <= 8) return dd[b-1];
      if (PARM[i] != 0 && b == 9) return (^dd) ^ (PARM[i] == 1);
      return 1'b1;
   endfunction

   // one negedge step of the line monitor for all three instances
   task automatic mon_step();
      for (int i = 0; i < 3; i++) begin
         logic o;
         int   b;
         o = out_v[i];
         if (!rst_n) begin
            m_busy[i] = 0;
            m_idle[i] = 1;
         end else begin
            if (m_busy[i] == 0) begin
               if (o == 1'b0) begin
                  if (m_idle[i] == 0) b2b[i]++;
                  m_busy[i] = 1; m_cyc[i] = 0; m_bad[i] = 0; m_got[i] = 8'h00;
                  m_has[i] = 1;
                  case (i)
                     0: if (q0.size() > 0) m_exp[i] = q0.pop_front(); else m_has[i] = 0;
                     1: if (q1.size() > 0) m_exp[i] = q1.pop_front(); else m_has[i] = 0;
                     default: if (q2.size() > 0) m_exp[i] = q2.pop_front(); else m_has[i] = 0;
                  endcase
                  if (m_has[i] == 0) check(1'b0, $sformatf("unexpected_frame_u%0d", i), 1, 0);
               end else begin
                  m_idle[i]++;
               end
            end
            if (m_busy[i] != 0) begin
               b = m_cyc[i] / DIV;
               if (o != exp_line(i, m_exp[i], b)) m_bad[i]++;
               if ((m_cyc[i] % DIV) == DIV/2 && b >= 1 && b <= 8) m_got[i][b-1] = o;
               m_cyc[i]++;
               if (m_cyc[i] == NBITS[i] * DIV) begin
                  m_busy[i] = 0;
                  m_idle[i] = 0;
                  frames[i]++;
                  if (m_has[i] != 0) begin
                     checks++;
                     if (m_bad[i] != 0) begin
                        errors++;
                        $display("FAIL frame_u%0d: got data 0x%02h with %0d bad cycles, required 0x%02h",
                                 i, m_got[i], m_bad[i], m_exp[i]);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (sgn_v != 3'b000 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(sgn_v == 3'b000, name, int'(sgn_v), 0);
      tick(3);
   endtask

   // single request from idle: latency, busy-fall timing and mid-bit samples
   task automatic send_one(input logic [7:0] d);
      int fall [3];
      push_all(d);
      order = 1'b1; data = d;
      @(negedge clk);
      check(sgn_v == 3'b000 && out_v == 3'b111, "lat_after_E", int'({sgn_v, out_v}), 7);
      @(negedge clk);
      check(sgn_v == 3'b111, "sgn_rise_E1", int'(sgn_v), 7);
      check(out_v == 3'b111, "out_high_E1", int'(out_v), 7);
      order = 1'b0;
      @(negedge clk);
      check(out_v == 3'b000, "out_fall_E2", int'(out_v), 0);
      for (int i = 0; i < 3; i++) begin fall[i] = -1; samp[i] = '0; end
      for (int n = 0; n < 400; n++) begin
         if (n > 0) @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (fall[i] < 0 && sgn_v[i] == 1'b0) fall[i] = n;
            if ((n % DIV) == DIV/2 && (n / DIV) < 12) samp[i][n/DIV] = out_v[i];
         end
         if (fall[0] >= 0 && fall[1] >= 0 && fall[2] >= 0) break;
      end
      for (int i = 0; i < 3; i++)
         check(fall[i] == SGN_FALL[i], $sformatf("sgn_fall_u%0d", i), fall[i], SGN_FALL[i]);
      tick(3);
   endtask

   initial begin
      int bad, f0 [3], bb [3];
      checks = 0; errors = 0;
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_cyc[i] = 0; m_bad[i] = 0; m_idle[i] = 1; m_has[i] = 0;
         frames[i] = 0; b2b[i] = 0; m_exp[i] = 8'h00; m_got[i] = 8'h00;
      end
      rst_n = 1'b0; order = 1'b1; data = 8'h00;
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
         begin
            // reset with order held high: no frame launches after release
            tick(1);
            check(out_v == 3'b111 && sgn_v == 3'b000 && full_v == 3'b000 && err_v == 3'b000,
                  "reset_values", int'({out_v, sgn_v, full_v, err_v}), 12'h700);
            tick(4);
            rst_n = 1'b1;
            bad = 0;
            for (int n = 0; n < 50; n++) begin
               @(negedge clk);
               if (out_v != 3'b111 || sgn_v != 3'b000 || err_v != 3'b000) bad++;
            end
            check(bad == 0, "order_high_at_release", bad, 0);
            check(frames[0] + frames[1] + frames[2] == 0, "no_frame_after_reset",
                  frames[0] + frames[1] + frames[2], 0);
            order = 1'b0;
            tick(5);

            // default frame 0xA5: start, 1,0,1,0,0,1,0,1, stop
            send_one(8'hA5);
            check(samp[0][9:0] == 10'h34A, "a5_bits_u0", int'(samp[0][9:0]), 10'h34A);

            // 0x07: even parity bit 1, odd parity bit 0
            send_one(8'h07);
            check(samp[1][8:0] == 9'h00E, "07_data_u1", int'(samp[1][8:0]), 9'h00E);
            check(samp[1][9] == 1'b1, "even_parity_07", int'(samp[1][9]), 1);
            check(samp[1][11:10] == 2'b11, "two_stop_bits", int'(samp[1][11:10]), 3);
            check(samp[2][9] == 1'b0, "odd_parity_07", int'(samp[2][9]), 0);
            check(samp[2][10] == 1'b1, "odd_stop_bit", int'(samp[2][10]), 1);

            // level request: long high phases yield exactly one frame each
            for (int i = 0; i < 3; i++) f0[i] = frames[i];
            push_all(8'h3C); push_all(8'hC3);
            order = 1'b1; data = 8'h3C; tick(50);
            order = 1'b0; tick(200);
            order = 1'b1; data = 8'hC3; tick(50);
            order = 1'b0; tick(200);
            wait_idle("level_idle_timeout");
            for (int i = 0; i < 3; i++)
               check(frames[i] - f0[i] == 2, $sformatf("level_frames_u%0d", i), frames[i] - f0[i], 2);

            // burst of six edges into a depth-4 FIFO: sixth is dropped
            for (int i = 0; i < 3; i++) begin f0[i] = frames[i]; bb[i] = b2b[i]; end
            for (int k = 1; k <= 6; k++) begin
               if (k <= 5) push_all(8'(k));
               order = 1'b1; data = 8'(k);
               @(negedge clk);
               if (k == 4) check(full_v == 3'b000, "not_full_edge4", int'(full_v), 0);
               if (k == 5) begin
                  check(full_v == 3'b111, "full_edge5", int'(full_v), 7);
                  check(err_v == 3'b000, "no_err_edge5", int'(err_v), 0);
               end
               if (k == 6) check(err_v == 3'b111, "err_edge6", int'(err_v), 7);
               order = 1'b0;
               @(negedge clk);
               if (k == 6) check(err_v == 3'b000, "err_one_cycle", int'(err_v), 0);
               tick(2);
            end
            wait_idle("burst_idle_timeout");
            for (int i = 0; i < 3; i++) begin
               check(frames[i] - f0[i] == 5, $sformatf("burst_frames_u%0d", i), frames[i] - f0[i], 5);
               check(b2b[i] - bb[i] == 4, $sformatf("burst_b2b_u%0d", i), b2b[i] - bb[i], 4);
            end
            check(q0.size() + q1.size() + q2.size() == 0, "queues_drained",
                  q0.size() + q1.size() + q2.size(), 0);
            check(full_v == 3'b000, "full_cleared", int'(full_v), 0);

            // reset during frame 2 of a three-deep queue
            for (int i = 0; i < 3; i++) f0[i] = frames[i];
            push_all(8'h11); push_all(8'h22); push_all(8'h33);
            order = 1'b1; data = 8'h11; tick(2); order = 1'b0; tick(2);
            order = 1'b1; data = 8'h22; tick(2); order = 1'b0; tick(2);
            order = 1'b1; data = 8'h33; tick(2); order = 1'b0; tick(2);
            tick(208);
            check(sgn_v == 3'b111, "busy_before_reset", int'(sgn_v), 7);
            rst_n = 1'b0;
            #1;
            check(out_v == 3'b111 && sgn_v == 3'b000 && full_v == 3'b000,
                  "async_reset_midframe", int'({out_v, sgn_v, full_v}), 9'h1C0);
            q0.delete(); q1.delete(); q2.delete();
            tick(3);
            rst_n = 1'b1;
            bad = 0;
            for (int n = 0; n < 500; n++) begin
               @(negedge clk);
               if (out_v != 3'b111 || sgn_v != 3'b000) bad++;
            end
            check(bad == 0, "no_residual_frame", bad, 0);
            for (int i = 0; i < 3; i++)
               check(frames[i] - f0[i] == 1, $sformatf("reset_frames_u%0d", i), frames[i] - f0[i], 1);

            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      join
   end

endmodule
